// File: rtl/de_operand_latch.sv
// Decode-to-execute pipeline register: picks forwarded operands, latches D into E,
// and raises a one-cycle load-use interlock when D needs a load still sitting in E.
module de_operand_latch #(
  parameter int DBITS     = 32,
  parameter int REGNO_SEL = 4,
  parameter int MUX_SEL   = 2,
  parameter int CTRL_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MUX_SEL-1:0]   src1_sel_D,
  input  logic [MUX_SEL-1:0]   src2_sel_D,
  input  logic                 use_src1_D,
  input  logic                 use_src2_D,
  input  logic [DBITS-1:0]     regval1_D,
  input  logic [DBITS-1:0]     regval2_D,
  input  logic [DBITS-1:0]     result_E,
  input  logic [DBITS-1:0]     result_M,
  input  logic [DBITS-1:0]     result_W,
  input  logic [DBITS-1:0]     imm_D,
  input  logic [REGNO_SEL-1:0] dest_D,
  input  logic                 wrt_en_D,
  input  logic                 mem_rd_D,
  input  logic                 noop_D,
  input  logic [CTRL_W-1:0]    ctrl_D,
  input  logic                 flush,
  output logic [DBITS-1:0]     opnd1_E,
  output logic [DBITS-1:0]     opnd2_E,
  output logic [DBITS-1:0]     imm_E,
  output logic [REGNO_SEL-1:0] dest_E,
  output logic                 wrt_en_E,
  output logic                 mem_rd_E,
  output logic                 noop_E,
  output logic [CTRL_W-1:0]    ctrl_E,
  output logic                 stall_D,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [MUX_SEL-1:0] SEL_E = MUX_SEL'(1);
  localparam logic [MUX_SEL-1:0] SEL_M = MUX_SEL'(2);
  localparam logic [MUX_SEL-1:0] SEL_W = MUX_SEL'(3);

  logic [DBITS-1:0]     opnd1_d, opnd1_q;
  logic [DBITS-1:0]     opnd2_d, opnd2_q;
  logic [DBITS-1:0]     imm_d, imm_q;
  logic [REGNO_SEL-1:0] dest_d, dest_q;
  logic                 wrt_en_d, wrt_en_q;
  logic                 mem_rd_d, mem_rd_q;
  logic                 noop_d, noop_q;
  logic [CTRL_W-1:0]    ctrl_d, ctrl_q;
  logic [CNT_W-1:0]     stall_cnt_d, stall_cnt_q;
  logic [DBITS-1:0]     fwd1, fwd2;
  logic                 stall;

  function automatic logic [DBITS-1:0] fwd_mux(
    input logic [MUX_SEL-1:0] sel,
    input logic [DBITS-1:0]   regval,
    input logic [DBITS-1:0]   res_e,
    input logic [DBITS-1:0]   res_m,
    input logic [DBITS-1:0]   res_w
  );
    logic [DBITS-1:0] v;
    v = regval;
    if (sel == SEL_E)      v = res_e;
    else if (sel == SEL_M) v = res_m;
    else if (sel == SEL_W) v = res_w;
    return v;
  endfunction

  always_comb begin
    fwd1 = fwd_mux(src1_sel_D, regval1_D, result_E, result_M, result_W);
    fwd2 = fwd_mux(src2_sel_D, regval2_D, result_E, result_M, result_W);
    stall = !flush && !noop_D && !noop_q && mem_rd_q &&
            ((use_src1_D && (src1_sel_D == SEL_E)) ||
             (use_src2_D && (src2_sel_D == SEL_E)));
  end

  // Flush and stall both inject a bubble; only a real interlock bumps the counter.
  always_comb begin
    opnd1_d     = '0;
    opnd2_d     = '0;
    imm_d       = '0;
    dest_d      = '0;
    ctrl_d      = '0;
    wrt_en_d    = 1'b0;
    mem_rd_d    = 1'b0;
    noop_d      = 1'b1;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = stall_cnt_q;
    end else if (stall) begin
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      opnd1_d  = fwd1;
      opnd2_d  = fwd2;
      imm_d    = imm_D;
      dest_d   = dest_D;
      ctrl_d   = ctrl_D;
      noop_d   = noop_D;
      wrt_en_d = wrt_en_D && !noop_D;
      mem_rd_d = mem_rd_D && !noop_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opnd1_q     <= '0;
      opnd2_q     <= '0;
      imm_q       <= '0;
      dest_q      <= '0;
      ctrl_q      <= '0;
      wrt_en_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      noop_q      <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      opnd1_q     <= opnd1_d;
      opnd2_q     <= opnd2_d;
      imm_q       <= imm_d;
      dest_q      <= dest_d;
      ctrl_q      <= ctrl_d;
      wrt_en_q    <= wrt_en_d;
      mem_rd_q    <= mem_rd_d;
      noop_q      <= noop_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign opnd1_E   = opnd1_q;
  assign opnd2_E   = opnd2_q;
  assign imm_E     = imm_q;
  assign dest_E    = dest_q;
  assign ctrl_E    = ctrl_q;
  assign wrt_en_E  = wrt_en_q;
  assign mem_rd_E  = mem_rd_q;
  assign noop_E    = noop_q;
  assign stall_D   = stall;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_de_operand_latch.sv
// Self-checking bench for de_operand_latch: vector table plus scoreboard of expected
// E-stage contents, with hand-built saturation and mid-stall reset sequences.
module tb_de_operand_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  src1_sel_D, src2_sel_D;
  logic        use_src1_D, use_src2_D;
  logic [31:0] regval1_D, regval2_D, result_E, result_M, result_W, imm_D;
  logic [3:0]  dest_D;
  logic        wrt_en_D, mem_rd_D, noop_D, flush;
  logic [7:0]  ctrl_D;
  logic [31:0] opnd1_E, opnd2_E, imm_E;
  logic [3:0]  dest_E;
  logic        wrt_en_E, mem_rd_E, noop_E, stall_D;
  logic [7:0]  ctrl_E;
  logic [3:0]  stall_cnt;

  de_operand_latch #(.DBITS(32), .REGNO_SEL(4), .MUX_SEL(2), .CTRL_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .src1_sel_D(src1_sel_D), .src2_sel_D(src2_sel_D),
    .use_src1_D(use_src1_D), .use_src2_D(use_src2_D),
    .regval1_D(regval1_D), .regval2_D(regval2_D),
    .result_E(result_E), .result_M(result_M), .result_W(result_W),
    .imm_D(imm_D), .dest_D(dest_D),
    .wrt_en_D(wrt_en_D), .mem_rd_D(mem_rd_D), .noop_D(noop_D),
    .ctrl_D(ctrl_D), .flush(flush),
    .opnd1_E(opnd1_E), .opnd2_E(opnd2_E), .imm_E(imm_E), .dest_E(dest_E),
    .wrt_en_E(wrt_en_E), .mem_rd_E(mem_rd_E), .noop_E(noop_E), .ctrl_E(ctrl_E),
    .stall_D(stall_D), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, flush;
    logic [1:0] sel1, sel2;
    logic       use1, use2, noop, wrt, mrd;
    logic [31:0] res_m;
  } stim_t;

  typedef struct {
    logic        stall, bub, noop, wrt, mrd;
    logic [3:0]  cnt, dest;
    logic [7:0]  ctrl;
    logic [31:0] o1, o2, imm;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_idx  = 0;

  function automatic vec_t mk(
    input logic rst, input logic fl, input logic [1:0] s1, input logic [1:0] s2,
    input logic u1, input logic u2, input logic nop, input logic wr, input logic mr,
    input logic est, input logic ebub, input logic enop, input logic ewr, input logic emr,
    input logic [3:0] ecnt, input logic [31:0] eo1, input logic [31:0] eo2);
    vec_t v;
    v.s.rst = rst;  v.s.flush = fl; v.s.sel1 = s1; v.s.sel2 = s2;
    v.s.use1 = u1;  v.s.use2 = u2;  v.s.noop = nop; v.s.wrt = wr; v.s.mrd = mr;
    v.s.res_m = 32'h33;
    v.e.stall = est; v.e.bub = ebub; v.e.noop = enop; v.e.wrt = ewr; v.e.mrd = emr;
    v.e.cnt = ecnt;  v.e.o1 = eo1;   v.e.o2 = eo2;
    v.e.imm = '0;    v.e.dest = '0;  v.e.ctrl = '0;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (row %0d)", name, act, req, row_idx);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
      return;
    end
    e = sb.pop_front();
    checkVal("opnd1_E", opnd1_E, e.o1);
    checkVal("opnd2_E", opnd2_E, e.o2);
    checkVal("imm_E", imm_E, e.imm);
    checkVal("dest_E", {28'd0, dest_E}, {28'd0, e.dest});
    checkVal("ctrl_E", {24'd0, ctrl_E}, {24'd0, e.ctrl});
    checkVal("noop_E", {31'd0, noop_E}, {31'd0, e.noop});
    checkVal("wrt_en_E", {31'd0, wrt_en_E}, {31'd0, e.wrt});
    checkVal("mem_rd_E", {31'd0, mem_rd_E}, {31'd0, e.mrd});
    checkVal("stall_cnt", {28'd0, stall_cnt}, {28'd0, e.cnt});
  endtask

  // Drive one D-stage cycle, check the combinational interlock, then the latched E state.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset      = v.s.rst;    flush      = v.s.flush;
    src1_sel_D = v.s.sel1;   src2_sel_D = v.s.sel2;
    use_src1_D = v.s.use1;   use_src2_D = v.s.use2;
    noop_D     = v.s.noop;   wrt_en_D   = v.s.wrt;   mem_rd_D = v.s.mrd;
    result_M   = v.s.res_m;
    imm_D      = 32'hA500_0000 | 32'(row_idx);
    dest_D     = 4'(row_idx);
    ctrl_D     = 8'(row_idx) ^ 8'h5A;
    e = v.e;
    if (!v.e.bub) begin
      e.imm  = imm_D;
      e.dest = dest_D;
      e.ctrl = ctrl_D;
    end
    sb.push_back(e);
    #1;
    checkVal("stall_D", {31'd0, stall_D}, {31'd0, v.e.stall});
    @(posedge clk);
    #1;
    checkOutput();
    row_idx++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [3:0] c;

    regval1_D = 32'h11; regval2_D = 32'h66;
    result_E  = 32'h22; result_M  = 32'h33; result_W = 32'h44;
    src1_sel_D = 2'd1; src2_sel_D = 2'd1; use_src1_D = 1'b1; use_src2_D = 1'b1;
    imm_D = 32'hDEAD_BEEF; dest_D = 4'h9; ctrl_D = 8'hC3;
    wrt_en_D = 1'b1; mem_rd_D = 1'b1; noop_D = 1'b0; flush = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset noop_E", {31'd0, noop_E}, 32'd1);
    checkVal("reset wrt_en_E", {31'd0, wrt_en_E}, 32'd0);
    checkVal("reset mem_rd_E", {31'd0, mem_rd_E}, 32'd0);
    checkVal("reset opnd1_E", opnd1_E, 32'd0);
    checkVal("reset stall_cnt", {28'd0, stall_cnt}, 32'd0);
    checkVal("reset stall_D", {31'd0, stall_D}, 32'd0);

    //            rst fl s1 s2 u1 u2 nop wr mr | st bub nop wr mr cnt o1     o2
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h11, 32'h66));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h22, 32'h22));
    tbl.push_back(mk(0, 0, 2, 2, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h33, 32'h33));
    tbl.push_back(mk(0, 0, 3, 3, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 32'h44, 32'h44));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 1, 32'h0,  32'h0));
    v = mk(0, 0, 0, 2, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 32'h11, 32'hABCD);
    v.s.res_m = 32'hABCD;
    tbl.push_back(v);
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 32'h11, 32'h66));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 32'h22, 32'h22));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 2, 32'h0,  32'h0));
    tbl.push_back(mk(0, 0, 2, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 2, 32'h33, 32'h66));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 3, 32'h0,  32'h0));
    tbl.push_back(mk(0, 0, 2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 3, 32'h33, 32'h66));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 3, 32'h11, 32'h66));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 3, 32'h0,  32'h0));
    tbl.push_back(mk(0, 0, 3, 0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 3, 32'h44, 32'h66));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 3, 32'h11, 32'h66));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 3, 32'h22, 32'h66));

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Alternate load / dependent consumer so every other cycle is a real stall.
    c = 4'd3;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, c, 32'h11, 32'h66));
      if (c != 4'hF) c = c + 4'd1;
      applyStimulus(mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, c, 32'h0, 32'h0));
    end
    checkVal("saturated stall_cnt", {28'd0, stall_cnt}, 32'hF);

    // Reset arriving while the interlock is asserted.
    applyStimulus(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 4'hF, 32'h11, 32'h66));
    applyStimulus(mk(1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 4'h0, 32'h0, 32'h0));
    applyStimulus(mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 4'h0, 32'h22, 32'h66));

    checkVal("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
